gcd_req_sequencer: RTL and testbench

//   Upstream issue/collect stage for the GCD unit. Buffers operand-pair requests
//   in a FIFO, presents one pair at a time to the GCD unit with a level

---
 rtl/gcd_req_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_gcd_req_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_req_sequencer.sv
// gcd_req_sequencer: issue/collect stage in front of the GCD unit.
//
// Operand-pair requests are queued in a small FIFO. One pair at a time is
// presented to the GCD unit with a single-cycle input_available pulse. The
// stage then waits for result_rdy, acknowledges it with a result_taken pulse
// and returns the result on a valid/ready response port. If the result does not
// arrive, a watchdog aborts the job and returns an error response instead.
//
// Ports
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   req_val_i / req_rdy_o   request handshake; req_a_i / req_b_i operands
//   resp_val_o / resp_rdy_i response handshake; resp_data_o result (0 on abort),
//                           resp_err_o set for a watchdog abort
//   gcd_operand_a_o/b_o     operands to the GCD unit, held for the whole job
//   gcd_input_available_o   one-cycle start pulse to the GCD unit
//   gcd_result_data_i       result from the GCD unit
//   gcd_result_rdy_i        result valid from the GCD unit (sampled only in WAIT)
//   gcd_result_taken_o      one-cycle acknowledge to the GCD unit
//   fifo_count_o            number of queued requests

module gcd_req_sequencer #(
  parameter int unsigned W       = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_val_i,
  output logic                     req_rdy_o,
  input  logic [W-1:0]             req_a_i,
  input  logic [W-1:0]             req_b_i,
  output logic                     resp_val_o,
  input  logic                     resp_rdy_i,
  output logic [W-1:0]             resp_data_o,
  output logic                     resp_err_o,
  output logic [W-1:0]             gcd_operand_a_o,
  output logic [W-1:0]             gcd_operand_b_o,
  output logic                     gcd_input_available_o,
  input  logic [W-1:0]             gcd_result_data_i,
  input  logic                     gcd_result_rdy_i,
  output logic                     gcd_result_taken_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount  = CW'(DEPTH);
  localparam logic [9:0]    TimeoutVal = 10'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [W-1:0]  mem_a_q [DEPTH];
  logic [W-1:0]  mem_b_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  state_e        state_q, state_d;

  assign fifo_empty = (count_q == '0);
  // The only pop point is the IDLE->ISSUE transition.
  assign pop        = (state_q == StIdle) && !fifo_empty;
  // A full FIFO still accepts a request in the cycle it is being popped.
  assign req_rdy_o  = (count_q != FullCount) || pop;
  assign push       = req_val_i && req_rdy_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= req_a_i;
      mem_b_q[wr_ptr_q] <= req_b_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Job FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic [W-1:0] op_a_q, op_a_d;
  logic [W-1:0] op_b_q, op_b_d;
  logic [W-1:0] resp_data_q, resp_data_d;
  logic         resp_val_q, resp_val_d;
  logic         resp_err_q, resp_err_d;
  logic         avail_q, avail_d;
  logic         taken_q, taken_d;
  logic [9:0]   wdog_q, wdog_d;

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    resp_data_d = resp_data_q;
    resp_val_d  = resp_val_q;
    resp_err_d  = resp_err_q;
    avail_d     = 1'b0;
    taken_d     = 1'b0;
    wdog_d      = wdog_q;

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          op_a_d  = mem_a_q[rd_ptr_q];
          op_b_d  = mem_b_q[rd_ptr_q];
          avail_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        // A result arriving in the timeout cycle still wins.
        if (gcd_result_rdy_i) begin
          resp_data_d = gcd_result_data_i;
          resp_err_d  = 1'b0;
          resp_val_d  = 1'b1;
          taken_d     = 1'b1;
          state_d     = StResp;
        end else if (wdog_q == TimeoutVal) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          resp_val_d  = 1'b1;
          state_d     = StResp;
        end else begin
          wdog_d = wdog_q + 10'd1;
        end
      end
      StResp: begin
        if (resp_rdy_i) begin
          resp_val_d = 1'b0;
          wdog_d     = '0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_a_q      <= '0;
      op_b_q      <= '0;
      resp_data_q <= '0;
      resp_val_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      avail_q     <= 1'b0;
      taken_q     <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      resp_data_q <= resp_data_d;
      resp_val_q  <= resp_val_d;
      resp_err_q  <= resp_err_d;
      avail_q     <= avail_d;
      taken_q     <= taken_d;
      wdog_q      <= wdog_d;
    end
  end

  assign gcd_operand_a_o       = op_a_q;
  assign gcd_operand_b_o       = op_b_q;
  assign gcd_input_available_o = avail_q;
  assign gcd_result_taken_o    = taken_q;
  assign resp_val_o            = resp_val_q;
  assign resp_data_o           = resp_data_q;
  assign resp_err_o            = resp_err_q;
  assign fifo_count_o          = count_q;

  // ---------------------------------------------------------------------------
  // Internal consistency checks
  // ---------------------------------------------------------------------------
  a_count_bound: assert property (@(posedge clk) disable iff (reset) count_q <= FullCount);
  a_avail_in_issue: assert property (@(posedge clk) disable iff (reset)
                                     avail_q |-> (state_q == StIssue));
  a_taken_in_resp: assert property (@(posedge clk) disable iff (reset)
                                    taken_q |-> (state_q == StResp));

endmodule

// File: tb/tb_gcd_req_sequencer.sv
// Bench for gcd_req_sequencer: directed scenarios plus a randomized phase, all
// checked against a transaction-level model (request queue, expected-response
// queue, Euclid reference) and a behavioural GCD-unit responder.

module tb_gcd_req_sequencer;
  localparam int unsigned W       = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam int          Limit   = 20 * TIMEOUT;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_val_i = 1'b0;
  logic          req_rdy_o;
  logic [W-1:0]  req_a_i = '0;
  logic [W-1:0]  req_b_i = '0;
  logic          resp_val_o;
  logic          resp_rdy_i;
  logic [W-1:0]  resp_data_o;
  logic          resp_err_o;
  logic [W-1:0]  gcd_operand_a_o;
  logic [W-1:0]  gcd_operand_b_o;
  logic          gcd_input_available_o;
  logic [W-1:0]  gcd_result_data_i;
  logic          gcd_result_rdy_i;
  logic          gcd_result_taken_o;
  logic [CW-1:0] fifo_count_o;

  gcd_req_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_val_i             (req_val_i),
    .req_rdy_o             (req_rdy_o),
    .req_a_i               (req_a_i),
    .req_b_i               (req_b_i),
    .resp_val_o            (resp_val_o),
    .resp_rdy_i            (resp_rdy_i),
    .resp_data_o           (resp_data_o),
    .resp_err_o            (resp_err_o),
    .gcd_operand_a_o       (gcd_operand_a_o),
    .gcd_operand_b_o       (gcd_operand_b_o),
    .gcd_input_available_o (gcd_input_available_o),
    .gcd_result_data_i     (gcd_result_data_i),
    .gcd_result_rdy_i      (gcd_result_rdy_i),
    .gcd_result_taken_o    (gcd_result_taken_o),
    .fifo_count_o          (fifo_count_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned x = a;
    int unsigned y = b;
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct packed {logic [W-1:0] a; logic [W-1:0] b;} pair_t;

  pair_t        req_q[$];      // accepted, not yet issued
  logic [W:0]   rsp_q[$];      // expected {err, data} of issued jobs
  logic [W-1:0] resp_log[$];   // data of completed handshakes
  bit           busy = 0;      // a job is issued and not yet handshaken
  bit           stuck = 0;     // GCD unit never answers
  bit           pend_push = 0;
  bit           pend_resp = 0;
  pair_t        pend_pair;
  pair_t        cur;
  pair_t        p;
  logic         prev_avail = 0, prev_rv = 0, prev_rdy = 0, prev_taken = 0;
  logic [W-1:0] prev_data;
  logic         prev_err;
  logic [W-1:0] last_data;
  logic         last_err;
  int           n_issue = 0;
  int           n_taken = 0;
  int           rdy_mode = 0;  // 0: resp_rdy low, 1: high, 2: random

  always @(negedge clk) begin
    if (reset) begin
      req_q.delete();
      rsp_q.delete();
      busy = 0; pend_push = 0; pend_resp = 0;
      prev_avail = 0; prev_rv = 0; prev_rdy = 0; prev_taken = 0;
    end else begin
      if (pend_push) req_q.push_back(pend_pair);
      if (pend_resp) busy = 0;
      pend_push = 0;
      pend_resp = 0;

      if (gcd_input_available_o) begin
        if (!prev_avail) begin
          check_eq("one_in_flight", busy, 0);
          check_eq("issue_nonempty", req_q.size() != 0, 1);
          if (req_q.size() != 0) begin
            p = req_q.pop_front();
            check_eq("issue_op_a", gcd_operand_a_o, p.a);
            check_eq("issue_op_b", gcd_operand_b_o, p.b);
            cur = p;
            rsp_q.push_back(stuck ? {1'b1, {W{1'b0}}} : {1'b0, gcd_ref(p.a, p.b)});
          end
          busy = 1;
          n_issue++;
        end else begin
          check_eq("avail_one_cycle", prev_avail, 0);
        end
      end else if (busy) begin
        check_eq("op_hold_a", gcd_operand_a_o, cur.a);
        check_eq("op_hold_b", gcd_operand_b_o, cur.b);
      end

      if (gcd_result_taken_o) begin
        check_eq("taken_after_rdy", prev_rdy, 1);
        check_eq("taken_one_cycle", prev_taken, 0);
        n_taken++;
      end

      check_eq("fifo_count", fifo_count_o, req_q.size());
      if (req_q.size() < DEPTH) check_eq("req_rdy_not_full", req_rdy_o, 1);

      if (resp_val_o) begin
        if (prev_rv) begin
          check_eq("resp_data_stable", resp_data_o, prev_data);
          check_eq("resp_err_stable", resp_err_o, prev_err);
        end else begin
          check_eq("resp_expected", rsp_q.size() != 0, 1);
          if (rsp_q.size() != 0) begin
            check_eq("resp_data", resp_data_o, rsp_q[0][W-1:0]);
            check_eq("resp_err", resp_err_o, rsp_q[0][W]);
          end
        end
        if (resp_rdy_i) begin
          pend_resp = 1;
          if (rsp_q.size() != 0) void'(rsp_q.pop_front());
          last_data = resp_data_o;
          last_err  = resp_err_o;
          resp_log.push_back(resp_data_o);
        end
      end

      prev_rv    = resp_val_o && !resp_rdy_i;
      prev_data  = resp_data_o;
      prev_err   = resp_err_o;
      prev_avail = gcd_input_available_o;
      prev_rdy   = gcd_result_rdy_i;
      prev_taken = gcd_result_taken_o;
      pend_push  = req_val_i && req_rdy_o;
      pend_pair  = '{a: req_a_i, b: req_b_i};
    end
  end

  // ---------------------------------------------------------------------------
  // Behavioural GCD unit
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] ga, gb;
    int dly, k;
    gcd_result_rdy_i  = 1'b0;
    gcd_result_data_i = '0;
    forever begin
      @(negedge clk);
      if (!reset && gcd_input_available_o && !stuck) begin
        ga  = gcd_operand_a_o;
        gb  = gcd_operand_b_o;
        dly = $urandom_range(0, 5);
        @(posedge clk);
        repeat (dly) @(posedge clk);
        #1;
        if (!reset) begin
          gcd_result_rdy_i  = 1'b1;
          gcd_result_data_i = gcd_ref(ga, gb);
          k = 0;
          do begin
            @(negedge clk);
            k++;
          end while (!gcd_result_taken_o && !reset && k < 8);
          if (!reset && !gcd_result_taken_o) check_eq("taken_seen", gcd_result_taken_o, 1);
          @(posedge clk);
          #1;
          gcd_result_rdy_i  = 1'b0;
          gcd_result_data_i = W'($urandom);
        end
      end
    end
  end

  // Response-ready driver
  initial begin
    resp_rdy_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       resp_rdy_i = 1'b0;
        1:       resp_rdy_i = 1'b1;
        default: resp_rdy_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    logic acc;
    int k = 0;
    req_val_i = 1'b1;
    req_a_i   = a;
    req_b_i   = b;
    forever begin
      @(negedge clk);
      acc = req_rdy_o;
      tick();
      k++;
      if (acc) break;
      if (k > Limit) begin
        check_eq("push_accept", acc, 1);
        break;
      end
    end
    req_val_i = 1'b0;
  endtask

  task automatic wait_idle(input string t);
    int k = 0;
    while ((req_q.size() != 0 || busy || pend_push) && k < Limit) begin
      @(negedge clk);
      k++;
    end
    if (k >= Limit) check_eq({t, "_drain"}, k < Limit, 1);
    tick();
  endtask

  task automatic wait_neg(input string t, input bit want_avail);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(want_avail ? gcd_input_available_o : resp_val_o) && k < Limit);
    if (k >= Limit) check_eq({t, "_seen"}, k < Limit, 1);
  endtask

  task automatic check_reset_vals(input string t);
    check_eq({t, "_req_rdy"}, req_rdy_o, 1);
    check_eq({t, "_resp_val"}, resp_val_o, 0);
    check_eq({t, "_resp_data"}, resp_data_o, 0);
    check_eq({t, "_resp_err"}, resp_err_o, 0);
    check_eq({t, "_avail"}, gcd_input_available_o, 0);
    check_eq({t, "_taken"}, gcd_result_taken_o, 0);
    check_eq({t, "_op_a"}, gcd_operand_a_o, 0);
    check_eq({t, "_op_b"}, gcd_operand_b_o, 0);
    check_eq({t, "_count"}, fifo_count_o, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int taken0, issue0, k, g;
    logic [W-1:0] held;
    logic [W-1:0] exp_log[6];
    exp_log = '{16'd3, 16'd6, 16'd1, 16'd25, 16'd9, 16'd4};

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    tick();
    reset = 1'b0;
    tick();

    // Single job
    rdy_mode = 1;
    taken0 = n_taken;
    push(16'd27, 16'd15);
    wait_idle("t1");
    check_eq("t1_data", last_data, 3);
    check_eq("t1_err", last_err, 0);
    check_eq("t1_taken", n_taken - taken0, 1);

    // Fill the FIFO behind an in-flight job, hold the response, then full push+pop
    resp_log.delete();
    rdy_mode = 0;
    tick();
    push(16'd27, 16'd15);
    push(16'd48, 16'd18);
    push(16'd7, 16'd5);
    push(16'd100, 16'd75);
    push(16'd9, 16'd0);
    @(negedge clk);
    check_eq("t2_count_full", fifo_count_o, 4);
    check_eq("t2_req_rdy_full", req_rdy_o, 0);
    wait_neg("t3_resp", 0);
    held   = resp_data_o;
    issue0 = n_issue;
    repeat (20) @(negedge clk);
    check_eq("t3_resp_val_held", resp_val_o, 1);
    check_eq("t3_data_held", resp_data_o, held);
    check_eq("t3_no_issue", n_issue, issue0);
    tick();
    req_val_i = 1'b1;
    req_a_i   = 16'd12;
    req_b_i   = 16'd8;
    rdy_mode  = 1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(resp_val_o && resp_rdy_i) && k < Limit);
    if (k >= Limit) check_eq("t5_handshake_seen", k < Limit, 1);
    @(negedge clk);
    check_eq("t5_req_rdy_popping", req_rdy_o, 1);
    check_eq("t5_count_before", fifo_count_o, 4);
    @(negedge clk);
    check_eq("t5_count_after", fifo_count_o, 4);
    check_eq("t5_issued", gcd_input_available_o, 1);
    tick();
    req_val_i = 1'b0;
    wait_idle("t2");
    check_eq("t2_log_len", resp_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < resp_log.size()) check_eq($sformatf("t2_order%0d", i), resp_log[i], exp_log[i]);
    end

    // Watchdog abort
    stuck  = 1;
    taken0 = n_taken;
    push(16'd5, 16'd10);
    wait_neg("t4_issue", 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_val_o && k < 3 * TIMEOUT);
    check_eq("t4_delay_ok", (k >= TIMEOUT + 1) && (k <= TIMEOUT + 2), 1);
    check_eq("t4_err", resp_err_o, 1);
    check_eq("t4_data", resp_data_o, 0);
    wait_idle("t4");
    check_eq("t4_no_taken", n_taken, taken0);

    // Reset in WAIT with a queued request
    push(16'd33, 16'd11);
    push(16'd8, 16'd4);
    repeat (5) tick();
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("t6");
    stuck = 0;
    tick();
    reset = 1'b0;
    tick();
    push(16'd21, 16'd14);
    wait_idle("t6");
    check_eq("t6_data", last_data, 7);
    check_eq("t6_err", last_err, 0);

    // Randomized traffic
    rdy_mode = 2;
    for (int j = 0; j < 40; j++) begin
      g = $urandom_range(1, 50);
      push(W'(g * $urandom_range(0, 40)), W'(g * $urandom_range(0, 40)));
      repeat ($urandom_range(0, 3)) tick();
    end
    rdy_mode = 1;
    wait_idle("rand");
    check_eq("rand_all_answered", rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
